score_bank: RTL

- Parametrised successor to the single-player score path: holds scores for NUM_PLAYERS players and detects hits from each IR receiver channel.
- Applies per-player power-up multipliers and snitch bonuses, saturating each score at SCORE_MAX.
- Continuously converts every score to BCD digits with a shared, round-robin sequential double-dabble engine.
- Sits between the IR receivers / screen timer and vga_controller; feeds score and digit buses directly to the display.

---
 rtl/score_bank.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/score_bank.sv
// Multi-player score bank: edge-detected hits with power-up multipliers and snitch bonuses,
// saturating scores, and a shared round-robin double-dabble converter feeding BCD digits.
module score_bank #(
  parameter int NUM_PLAYERS  = 2,
  parameter int SCORE_W      = 14,
  parameter int NUM_DIGITS   = 4,
  parameter int SCORE_MAX    = 9999,
  parameter int HIT_POINTS   = 10,
  parameter int SNITCH_BONUS = 150,
  parameter int PIDX_W       = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             game_active,
  input  logic                             clear_scores,
  input  logic [NUM_PLAYERS-1:0]           hit,
  input  logic [2*NUM_PLAYERS-1:0]         powerup,
  input  logic [NUM_PLAYERS-1:0]           snitch_bonus,
  output logic [NUM_PLAYERS*SCORE_W-1:0]   score,
  output logic [NUM_PLAYERS*NUM_DIGITS*4-1:0] digits,
  output logic                             digits_valid,
  output logic [PIDX_W-1:0]                digits_player,
  output logic                             conv_busy
);

  localparam int SUM_W = SCORE_W + 4;
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam int BCD_W = NUM_DIGITS * 4;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;

  conv_state_t state, state_next;

  logic [NUM_PLAYERS-1:0] hit_prev;
  logic [NUM_PLAYERS-1:0] hit_edge;
  logic [SCORE_W-1:0]     score_q    [NUM_PLAYERS];
  logic [SCORE_W-1:0]     score_next [NUM_PLAYERS];
  logic [SUM_W-1:0]       add        [NUM_PLAYERS];
  logic [SUM_W-1:0]       sum        [NUM_PLAYERS];
  logic [BCD_W-1:0]       digits_q   [NUM_PLAYERS];

  logic [PIDX_W-1:0]  ptr;
  logic [SCORE_W-1:0] shift_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   cnt;

  assign hit_edge = hit & ~hit_prev & {NUM_PLAYERS{game_active}};

  always_ff @(posedge clock) begin
    if (reset) hit_prev <= '0;
    else       hit_prev <= hit;
  end

  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      add[p] = '0;
      if (hit_edge[p])
        add[p] = SUM_W'(HIT_POINTS) * (SUM_W'(powerup[2*p +: 2]) + SUM_W'(1));
      if (snitch_bonus[p] & game_active)
        add[p] = add[p] + SUM_W'(SNITCH_BONUS);
      sum[p] = SUM_W'(score_q[p]) + add[p];
      score_next[p] = (sum[p] > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum[p][SCORE_W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (reset || clear_scores) score_q[p] <= '0;
      else                       score_q[p] <= score_next[p];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (cnt == CNT_W'(SCORE_W - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear_scores) state_next = IDLE;
  end

  // Add-3 correction applied to every BCD nibble before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear_scores) begin
      ptr           <= '0;
      shift_q       <= '0;
      bcd_q         <= '0;
      cnt           <= '0;
      digits_valid  <= 1'b0;
      digits_player <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) digits_q[p] <= '0;
    end else begin
      digits_valid <= 1'b0;
      case (state)
        LOAD: begin
          shift_q <= score_q[ptr];
          bcd_q   <= '0;
          cnt     <= '0;
        end
        SHIFT: begin
          {bcd_q, shift_q} <= {bcd_adj[BCD_W-2:0], shift_q, 1'b0};
          cnt              <= cnt + CNT_W'(1);
        end
        DONE: begin
          digits_q[ptr] <= bcd_q;
          digits_valid  <= 1'b1;
          digits_player <= ptr;
          ptr <= (ptr == PIDX_W'(NUM_PLAYERS - 1)) ? '0 : ptr + PIDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  genvar gp;
  generate
    for (gp = 0; gp < NUM_PLAYERS; gp++) begin : g_pack
      assign score[gp*SCORE_W +: SCORE_W] = score_q[gp];
      assign digits[gp*BCD_W +: BCD_W]    = digits_q[gp];
    end
  endgenerate

  assign conv_busy = (state != IDLE);

endmodule
